// File: rtl/scan_response_checker.sv
// Scan unload checker: one capture strobe, CHAIN_LEN shift cycles comparing so against exp_bit
// (maskable); reports sticky fail, saturating mismatch count and first failing bit index.
module scan_response_checker #(
  parameter int CHAIN_LEN = 8,
  parameter int IDX_W     = 3,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             so,
  input  logic             exp_bit,
  input  logic             mask_bit,
  output logic             capture,
  output logic             scan_en,
  output logic [IDX_W-1:0] bit_idx,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] err_count,
  output logic [IDX_W-1:0] first_err_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t             state_q, state_d;
  logic               capture_q, capture_d;
  logic               scan_en_q, scan_en_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [IDX_W-1:0]   first_err_idx_q, first_err_idx_d;
  logic               mismatch;

  assign mismatch = (so ^ exp_bit) & ~mask_bit;

  always_comb begin
    state_d         = state_q;
    capture_d       = 1'b0;
    done_d          = 1'b0;
    scan_en_d       = scan_en_q;
    bit_idx_d       = bit_idx_q;
    busy_d          = busy_q;
    fail_d          = fail_q;
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;

    case (state_q)
      S_IDLE: begin
        scan_en_d = 1'b0;
        busy_d    = 1'b0;
        if (start) begin
          state_d         = S_CAPTURE;
          capture_d       = 1'b1;
          busy_d          = 1'b1;
          bit_idx_d       = '0;
          fail_d          = 1'b0;
          err_count_d     = '0;
          first_err_idx_d = '0;
        end
      end
      S_CAPTURE: begin
        state_d   = S_SHIFT;
        scan_en_d = 1'b1;
        busy_d    = 1'b1;
        bit_idx_d = '0;
      end
      S_SHIFT: begin
        if (mismatch) begin
          if (err_count_q != CNT_MAX) err_count_d = err_count_q + CNT_W'(1);
          // only the first mismatch of the run records its position
          if (!fail_q) begin
            fail_d          = 1'b1;
            first_err_idx_d = bit_idx_q;
          end
        end
        if (bit_idx_q == LAST_IDX) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          scan_en_d = 1'b0;
          bit_idx_d = '0;
        end else begin
          bit_idx_d = bit_idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        scan_en_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      capture_q       <= 1'b0;
      scan_en_q       <= 1'b0;
      bit_idx_q       <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      fail_q          <= 1'b0;
      err_count_q     <= '0;
      first_err_idx_q <= '0;
    end else begin
      state_q         <= state_d;
      capture_q       <= capture_d;
      scan_en_q       <= scan_en_d;
      bit_idx_q       <= bit_idx_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      fail_q          <= fail_d;
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;
    end
  end

  assign capture       = capture_q;
  assign scan_en       = scan_en_q;
  assign bit_idx       = bit_idx_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign fail          = fail_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_scan_response_checker.sv
// Randomized bench for scan_response_checker: default instance plus a 2-bit-counter instance in lockstep.
module tb_scan_response_checker;

  logic       clk = 1'b0;
  logic       rst, start, so, exp_bit, mask_bit;

  logic       capture, scan_en, busy, done, fail;
  logic [2:0] bit_idx, first_err_idx;
  logic [3:0] err_count;

  logic       s_capture, s_scan_en, s_busy, s_done, s_fail;
  logic [2:0] s_bit_idx, s_first_err_idx;
  logic [1:0] s_err_count;

  int checks = 0;
  int errors = 0;

  int prev_fail, prev_cnt, prev_cnt_sat, prev_first;

  always #5 clk = ~clk;

  scan_response_checker #(.CHAIN_LEN(8), .IDX_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .so(so), .exp_bit(exp_bit), .mask_bit(mask_bit),
    .capture(capture), .scan_en(scan_en), .bit_idx(bit_idx), .busy(busy), .done(done),
    .fail(fail), .err_count(err_count), .first_err_idx(first_err_idx)
  );

  scan_response_checker #(.CHAIN_LEN(8), .IDX_W(3), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .so(so), .exp_bit(exp_bit), .mask_bit(mask_bit),
    .capture(s_capture), .scan_en(s_scan_en), .bit_idx(s_bit_idx), .busy(s_busy), .done(s_done),
    .fail(s_fail), .err_count(s_err_count), .first_err_idx(s_first_err_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_capture"}, 32'(capture), 0);
    check({tag, "_scan_en"}, 32'(scan_en), 0);
    check({tag, "_bit_idx"}, 32'(bit_idx), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_fail"}, 32'(fail), 0);
    check({tag, "_err_count"}, 32'(err_count), 0);
    check({tag, "_first_err"}, 32'(first_err_idx), 0);
    check({tag, "_sat_busy"}, 32'(s_busy), 0);
    check({tag, "_sat_err_count"}, 32'(s_err_count), 0);
  endtask

  // Caller sits at a negedge with the DUT in IDLE; returns at the negedge of the cycle after done.
  task automatic run(input logic [7:0] s, input logic [7:0] e, input logic [7:0] m,
                     input int pulse_at, input bit keep);
    int cnt, first, exp_cnt, exp_sat;
    cnt   = 0;
    first = 0;
    for (int k = 0; k < 8; k++) begin
      if ((s[k] != e[k]) && !m[k]) begin
        if (cnt == 0) first = k;
        cnt++;
      end
    end
    exp_cnt = (cnt > 15) ? 15 : cnt;
    exp_sat = (cnt > 3) ? 3 : cnt;

    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = keep;
    check("cap_strobe", 32'(capture), 1);
    check("cap_busy", 32'(busy), 1);
    check("cap_scan_en", 32'(scan_en), 0);
    check("cap_cleared_fail", 32'(fail), 0);
    check("cap_cleared_cnt", 32'(err_count), 0);
    check("cap_cleared_first", 32'(first_err_idx), 0);
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("shift_scan_en", 32'(scan_en), 1);
      check("shift_bit_idx", 32'(bit_idx), k);
      check("shift_capture", 32'(capture), 0);
      check("shift_busy", 32'(busy), 1);
      check("shift_done", 32'(done), 0);
      so       = s[k];
      exp_bit  = e[k];
      mask_bit = m[k];
      start    = (k == pulse_at) ? 1'b1 : keep;
      @(posedge clk);
    end
    @(negedge clk);
    start = (pulse_at == 8) ? 1'b1 : keep;
    check("done_pulse", 32'(done), 1);
    check("done_busy", 32'(busy), 0);
    check("done_scan_en", 32'(scan_en), 0);
    check("done_bit_idx", 32'(bit_idx), 0);
    check("res_fail", 32'(fail), (cnt > 0) ? 1 : 0);
    check("res_err_count", 32'(err_count), exp_cnt);
    check("res_first_err", 32'(first_err_idx), first);
    check("res_sat_err_count", 32'(s_err_count), exp_sat);
    check("res_sat_first_err", 32'(s_first_err_idx), first);
    check("res_sat_done", 32'(s_done), 1);
    @(posedge clk);
    @(negedge clk);
    start = keep;
    check("idle_done_low", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_capture", 32'(capture), 0);
    check("idle_hold_fail", 32'(fail), (cnt > 0) ? 1 : 0);
    check("idle_hold_cnt", 32'(err_count), exp_cnt);
    prev_fail    = (cnt > 0) ? 1 : 0;
    prev_cnt     = exp_cnt;
    prev_cnt_sat = exp_sat;
    prev_first   = first;
  endtask

  task automatic idle_hold(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_busy", 32'(busy), 0);
      check("hold_fail", 32'(fail), prev_fail);
      check("hold_err_count", 32'(err_count), prev_cnt);
      check("hold_first_err", 32'(first_err_idx), prev_first);
      check("hold_sat_err_count", 32'(s_err_count), prev_cnt_sat);
    end
  endtask

  task automatic reset_mid_shift();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      so       = 1'($urandom_range(0, 1));
      exp_bit  = ~so;
      mask_bit = 1'b0;
      if (k == 4) begin
        check("pre_rst_bit_idx", 32'(bit_idx), 4);
        rst = 1'b1;
      end
      @(posedge clk);
    end
    @(negedge clk);
    check_all_zero("rst_mid");
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("post_rst_no_done", 32'(done), 0);
      check("post_rst_idle", 32'(busy), 0);
    end
    prev_fail = 0; prev_cnt = 0; prev_cnt_sat = 0; prev_first = 0;
  endtask

  initial begin
    logic [7:0] e, s, m;
    rst = 1'b1; start = 1'b0; so = 1'b0; exp_bit = 1'b0; mask_bit = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    prev_fail = 0; prev_cnt = 0; prev_cnt_sat = 0; prev_first = 0;
    idle_hold(2);

    run(8'b1011_0010, 8'b1011_0010, 8'h00, -1, 1'b0);
    e = 8'($urandom);
    run(e ^ 8'b0100_0100, e, 8'h00, -1, 1'b0);
    idle_hold(3);
    e = 8'($urandom);
    run(e ^ 8'b0010_1010, e, 8'b0000_1010, -1, 1'b0);
    e = 8'($urandom);
    run(~e, e, 8'h00, -1, 1'b0);
    idle_hold(1);

    e = 8'($urandom);
    run(e ^ 8'b1000_0001, e, 8'h00, 3, 1'b1);
    e = 8'($urandom);
    run(e, e, 8'h00, -1, 1'b1);
    e = 8'($urandom);
    run(e ^ 8'b0001_0000, e, 8'h00, -1, 1'b0);
    idle_hold(2);

    reset_mid_shift();
    e = 8'($urandom);
    run(e ^ 8'b1001_0000, e, 8'h00, -1, 1'b0);

    for (int r = 0; r < 30; r++) begin
      e = 8'($urandom);
      s = 8'($urandom);
      m = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      run(s, e, m, $urandom_range(0, 12), (r < 29) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    idle_hold(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_response_checker.md
Name: scan_response_checker

Overview:
- Observe-side companion to the scan chain built from basic_ff cells. The stimulus side drives patterns in; this block unloads and checks responses.
- On request it issues one capture pulse, then shifts the chain out for exactly CHAIN_LEN cycles.
- Each shifted-out bit is compared against an expected bit, with optional masking.
- Reports pass/fail, a saturating mismatch count and the index of the first failing bit.

Parameters:
- CHAIN_LEN, 8, number of flops in the scan chain (≥1).
- IDX_W, 3, width of bit index; 2^IDX_W ≥ CHAIN_LEN required.
- CNT_W, 4, width of mismatch counter; saturates at 2^CNT_W-1.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request one capture+unload run; sampled only in IDLE.
- so  input  1  serial scan-out bit from chain tail.
- exp_bit  input  1  expected value of so for the current bit_idx.
- mask_bit  input  1  1 = ignore this bit (X / don't-care).
- capture  output  1  one-cycle functional-capture strobe to chain.
- scan_en  output  1  1 = chain in shift mode.
- bit_idx  output  IDX_W  index of bit currently on so (0 = first out).
- busy  output  1  high in CAPTURE and SHIFT.
- done  output  1  one-cycle pulse at end of run.
- fail  output  1  sticky: ≥1 unmasked mismatch in last run.
- err_count  output  CNT_W  unmasked mismatches in last run, saturating.
- first_err_idx  output  IDX_W  bit_idx of first mismatch; valid only when fail=1, else 0.

Behaviour:
- Reset (rst=1 at edge, any state):
  - State goes to IDLE.
  - All outputs go to 0: capture, scan_en, bit_idx, busy, done, fail, err_count, first_err_idx.
  - A run in progress is abandoned; no done pulse is issued.
- States: IDLE, CAPTURE, SHIFT, DONE. All outputs are registered.
- IDLE:
  - start=1 moves to CAPTURE.
  - On the same edge, fail, err_count and first_err_idx clear to 0.
  - start=0 stays in IDLE; results of the previous run are held.
- CAPTURE (1 cycle):
  - capture=1, scan_en=0, busy=1.
  - Always moves to SHIFT with bit_idx=0.
- SHIFT (CHAIN_LEN cycles):
  - scan_en=1, busy=1, capture=0.
  - Each cycle, so, exp_bit and mask_bit are sampled for the current bit_idx.
  - mismatch = (so XOR exp_bit) AND NOT mask_bit.
  - On mismatch: err_count += 1 unless at max (saturates, never wraps).
  - On the first mismatch of the run: fail←1 and first_err_idx←bit_idx; later mismatches do not update first_err_idx.
  - bit_idx increments each cycle. When bit_idx = CHAIN_LEN-1, that bit is compared, then the state moves to DONE.
- DONE (1 cycle):
  - done=1, busy=0, scan_en=0, bit_idx←0.
  - Always moves to IDLE.
- Timing: start sampled at edge 0 gives capture high in cycle 1, SHIFT in cycles 2..CHAIN_LEN+1, done in cycle CHAIN_LEN+2.
- start while busy or in DONE is ignored; it is not queued.
- start held high continuously restarts a run on every return to IDLE: one idle cycle between runs, results cleared at each restart.
- Masked mismatches never affect fail, err_count or first_err_idx.
- CHAIN_LEN=1: exactly one SHIFT cycle.

Test Plan:
- Reset mid-SHIFT:
  - Stimulus: CHAIN_LEN=8; start; assert rst at bit_idx=4.
  - Required: next cycle all outputs 0, state IDLE, no done pulse; a new start then runs the full 8 bits.
- Clean run:
  - Stimulus: so = exp_bit = 8'b1011_0010 (bit 0 first), mask=0.
  - Required: capture at cycle 1; scan_en high cycles 2–9; done at cycle 10; fail=0, err_count=0.
- Two mismatches:
  - Stimulus: flip so at bit_idx 2 and 6.
  - Required: fail=1, err_count=2, first_err_idx=2, all held after done until next start.
- Masking:
  - Stimulus: mismatches at bit_idx 1, 3, 5; mask_bit=1 at 1 and 3.
  - Required: err_count=1, first_err_idx=5.
- Saturation:
  - Stimulus: CNT_W=2, CHAIN_LEN=8, every bit mismatched.
  - Required: err_count=3 (not wrapped), first_err_idx=0.
- start while busy, then held:
  - Stimulus: pulse start during SHIFT, then hold start=1.
  - Required: first run unaffected; after done, one IDLE cycle; second run begins with fail and err_count cleared.
